rx_word_packer: RTL and testbench



---
 rtl/rx_word_packer_pkg.sv | 15 +
 rtl/rx_word_packer_if.sv | 29 ++
 rtl/rx_word_packer_word_fifo.sv | 74 +++++++
 rtl/rx_word_packer.sv | 102 ++++++++++
 tb/tb_rx_word_packer.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/rx_word_packer_pkg.sv
// Shared constants and state encoding for the receive-side word packer.
package rx_word_packer_pkg;

    // Default byte width delivered by the UART receiver.
    localparam int DBIT_DEF   = 8;
    // A packed word is two received bytes, high byte first.
    localparam int WORD_W_DEF = 2 * DBIT_DEF;

    // Byte pairing state: waiting for the high byte or for the low byte.
    typedef enum logic {
        WAIT_HI = 1'b0,
        WAIT_LO = 1'b1
    } pair_state_e;

endpackage

// File: rtl/rx_word_packer_if.sv
// Byte input / word output bundle of rx_word_packer.
interface rx_word_packer_if #(
    parameter int DBIT = 8,
    parameter int ABIT = 2
);
    logic [DBIT-1:0] rx_data;
    logic            rx_done;
    logic            rd;
    logic            clr_ovf;
    logic [DBIT-1:0] data_high;
    logic [DBIT-1:0] data_low;
    logic            empty;
    logic            full;
    logic [ABIT:0]   count;
    logic            half;
    logic            overflow;

    // Byte source / word consumer side.
    modport master (
        output rx_data, rx_done, rd, clr_ovf,
        input  data_high, data_low, empty, full, count, half, overflow
    );

    // Packer side.
    modport slave (
        input  rx_data, rx_done, rd, clr_ovf,
        output data_high, data_low, empty, full, count, half, overflow
    );
endinterface

// File: rtl/rx_word_packer_word_fifo.sv
// First-word-fall-through word FIFO with occupancy count.
// The head is presented combinationally while non-empty; when empty the last
// presented head is held so the output never goes X.
module word_fifo #(
    parameter int DBIT  = 8,
    parameter int DEPTH = 4,
    parameter int ABIT  = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [2*DBIT-1:0] wdata,
    input  logic              pop,
    output logic [2*DBIT-1:0] rdata,
    output logic              empty,
    output logic              full,
    output logic [ABIT:0]     count,
    output logic              drop
);
    localparam int WW = 2 * DBIT;

    logic [WW-1:0]   mem [DEPTH];
    logic [ABIT-1:0] wr_ptr_q, wr_ptr_d;
    logic [ABIT-1:0] rd_ptr_q, rd_ptr_d;
    logic [ABIT:0]   count_q, count_d;
    logic [WW-1:0]   hold_q, hold_d;
    logic            do_pop, do_push;

    // Status comes only from the registered count.
    assign empty  = (count_q == '0);
    assign full   = (count_q == (ABIT+1)'(DEPTH));
    assign count  = count_q;

    // A full FIFO still accepts a push when a pop frees a slot on the same edge.
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign drop    = push & full & ~do_pop;

    assign rdata = empty ? hold_q : mem[rd_ptr_q];

    // Next-state for pointers, count and the held head word.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        hold_d   = hold_q;
        if (do_push) wr_ptr_d = wr_ptr_q + ABIT'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + ABIT'(1);
        if (do_push && !do_pop) count_d = count_q + (ABIT+1)'(1);
        if (do_pop && !do_push) count_d = count_q - (ABIT+1)'(1);
        if (!empty) hold_d = mem[rd_ptr_q];
    end

    // Control registers, cleared by the asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            hold_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            hold_q   <= hold_d;
        end
    end

    // Word storage; contents are don't-care after reset.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/rx_word_packer.sv
// Pairs UART receive bytes into words (high byte first), queues them in a
// FWFT FIFO, discards an orphan high byte after an inter-byte timeout and
// flags words lost to a full FIFO.
module rx_word_packer
    import rx_word_packer_pkg::*;
#(
    parameter int DBIT      = DBIT_DEF,
    parameter int DEPTH     = 4,
    parameter int ABIT      = 2,
    parameter int TO_CYCLES = 1000000,
    parameter int TOBIT     = 20
) (
    input  logic              clk,
    input  logic              reset_n,
    rx_word_packer_if.slave   bus
);
    pair_state_e      state_q, state_d;
    logic [DBIT-1:0]  hi_q, hi_d;
    logic [TOBIT-1:0] to_cnt_q, to_cnt_d;
    logic             ovf_q, ovf_d;
    logic             push;
    logic             drop;
    logic [2*DBIT-1:0] wdata;
    logic [2*DBIT-1:0] rdata;

    // The word is pushed on the same edge as the low-byte tick.
    assign wdata = {hi_q, bus.rx_data};

    // Pairing FSM, timeout counter and sticky overflow next-state.
    always_comb begin
        state_d  = state_q;
        hi_d     = hi_q;
        to_cnt_d = to_cnt_q;
        push     = 1'b0;
        case (state_q)
            WAIT_HI: begin
                if (bus.rx_done) begin
                    hi_d     = bus.rx_data;
                    to_cnt_d = '0;
                    state_d  = WAIT_LO;
                end
            end
            WAIT_LO: begin
                // A low byte arriving on the timeout cycle still completes the word.
                if (bus.rx_done) begin
                    push     = 1'b1;
                    to_cnt_d = '0;
                    state_d  = WAIT_HI;
                end else if (to_cnt_q == TOBIT'(TO_CYCLES - 1)) begin
                    to_cnt_d = '0;
                    state_d  = WAIT_HI;
                end else begin
                    to_cnt_d = to_cnt_q + TOBIT'(1);
                end
            end
            default: state_d = WAIT_HI;
        endcase

        // Set beats clear when both happen together.
        ovf_d = ovf_q;
        if (bus.clr_ovf) ovf_d = 1'b0;
        if (drop)        ovf_d = 1'b1;
    end

    // Pairing and flag registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= WAIT_HI;
            hi_q     <= '0;
            to_cnt_q <= '0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            hi_q     <= hi_d;
            to_cnt_q <= to_cnt_d;
            ovf_q    <= ovf_d;
        end
    end

    word_fifo #(
        .DBIT  (DBIT),
        .DEPTH (DEPTH),
        .ABIT  (ABIT)
    ) u_fifo (
        .clk   (clk),
        .rst_n (reset_n),
        .push  (push),
        .wdata (wdata),
        .pop   (bus.rd),
        .rdata (rdata),
        .empty (bus.empty),
        .full  (bus.full),
        .count (bus.count),
        .drop  (drop)
    );

    assign bus.data_high = rdata[2*DBIT-1:DBIT];
    assign bus.data_low  = rdata[DBIT-1:0];
    assign bus.half      = (state_q == WAIT_LO);
    assign bus.overflow  = ovf_q;

endmodule

// File: tb/tb_rx_word_packer.sv
// Randomised + directed bench for rx_word_packer with a queue-based reference
// model and a separate pop monitor acting as scoreboard checker.
module tb_rx_word_packer;
    localparam int DBIT  = 8;
    localparam int DEPTH = 4;
    localparam int ABIT  = 2;
    localparam int TO    = 16;
    localparam int TOBIT = 5;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    rx_word_packer_if #(.DBIT(DBIT), .ABIT(ABIT)) bus ();

    rx_word_packer #(
        .DBIT(DBIT), .DEPTH(DEPTH), .ABIT(ABIT), .TO_CYCLES(TO), .TOBIT(TOBIT)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model: expected FIFO contents plus pairing/overflow state.
    logic [15:0] exp_q [$];
    int          m_cnt;
    bit          m_half;
    bit          m_ovf;
    logic [7:0]  m_hi;
    int          m_idle;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h @%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_cnt  = 0;
        m_half = 1'b0;
        m_ovf  = 1'b0;
        m_hi   = '0;
        m_idle = 0;
    endtask

    // Behaviour of one clock edge given the inputs applied for it.
    task automatic model_edge(input logic done, input logic [7:0] d, input logic r, input logic c);
        bit pop;
        bit set_ovf;
        pop     = r && (m_cnt > 0);
        set_ovf = 1'b0;
        if (done) begin
            if (!m_half) begin
                m_half = 1'b1;
                m_hi   = d;
                m_idle = 0;
            end else begin
                m_half = 1'b0;
                if (m_cnt < DEPTH || pop) begin
                    exp_q.push_back({m_hi, d});
                    m_cnt++;
                end else begin
                    set_ovf = 1'b1;
                end
            end
        end else if (m_half) begin
            m_idle++;
            if (m_idle >= TO) m_half = 1'b0;
        end
        if (c) m_ovf = 1'b0;
        if (set_ovf) m_ovf = 1'b1;
        if (pop) m_cnt--;
    endtask

    task automatic check_state(input string tag);
        chk({tag, "_count"}, 32'(bus.count), 32'(m_cnt));
        chk({tag, "_empty"}, 32'(bus.empty), 32'(m_cnt == 0));
        chk({tag, "_full"},  32'(bus.full),  32'(m_cnt == DEPTH));
        chk({tag, "_half"},  32'(bus.half),  32'(m_half));
        chk({tag, "_ovf"},   32'(bus.overflow), 32'(m_ovf));
        if (m_cnt > 0 && exp_q.size() > 0)
            chk({tag, "_head"}, 32'({bus.data_high, bus.data_low}), 32'(exp_q[0]));
    endtask

    // Entered at posedge+1: apply inputs, model the coming edge, check after it.
    task automatic step(input logic done, input logic [7:0] d, input logic r, input logic c);
        bus.rx_done = done;
        bus.rx_data = d;
        bus.rd      = r;
        bus.clr_ovf = c;
        model_edge(done, d, r, c);
        @(posedge clk);
        #1;
        check_state("st");
    endtask

    task automatic pair(input logic [7:0] h, input logic [7:0] l);
        step(1'b1, h, 1'b0, 1'b0);
        step(1'b1, l, 1'b0, 1'b0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic pops(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
    endtask

    // Reset asserted between clock edges; outputs must clear without a clock.
    task automatic async_reset();
        #2;
        reset_n     = 1'b0;
        bus.rx_done = 1'b0;
        bus.rd      = 1'b0;
        bus.clr_ovf = 1'b0;
        #1;
        model_reset();
        chk("arst_empty", 32'(bus.empty), 32'd1);
        chk("arst_count", 32'(bus.count), 32'd0);
        chk("arst_half",  32'(bus.half),  32'd0);
        chk("arst_full",  32'(bus.full),  32'd0);
        chk("arst_data",  32'({bus.data_high, bus.data_low}), 32'd0);
        @(negedge clk);
        #1 reset_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: each DUT pop must deliver the oldest expected word.
    always @(negedge clk) begin
        logic [15:0] e;
        if (reset_n && bus.rd && !bus.empty) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL pop_unexpected actual=%0h expected=none @%0t",
                         {bus.data_high, bus.data_low}, $time);
            end else begin
                e = exp_q.pop_front();
                chk("pop_word", 32'({bus.data_high, bus.data_low}), 32'(e));
            end
        end
    end

    initial begin
        logic [7:0] h;
        bus.rx_done = 1'b0;
        bus.rx_data = '0;
        bus.rd      = 1'b0;
        bus.clr_ovf = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk) reset_n = 1'b1;
        @(posedge clk);
        #1;
        check_state("reset");
        chk("reset_data", 32'({bus.data_high, bus.data_low}), 32'd0);

        // Basic pairing, one-cycle latency.
        pair(8'h12, 8'h34);
        pops(1);

        // Fill, overflow on the fifth word, drain in order, clear flag.
        for (int i = 0; i < 4; i++) begin
            h = 8'hA1 + 8'(16 * i);
            pair(h, h + 8'h01);
        end
        pair(8'hE1, 8'hE2);
        pops(5);
        step(1'b0, 8'h00, 1'b0, 1'b1);

        // Full FIFO with pop coinciding with the low-byte tick.
        for (int i = 0; i < 4; i++) begin
            h = 8'h10 + 8'(16 * i);
            pair(h, h + 8'h05);
        end
        step(1'b1, 8'h5A, 1'b0, 1'b0);
        step(1'b1, 8'h5B, 1'b1, 1'b0);
        pops(5);

        // Orphan high byte times out; a late-but-in-time low byte still pairs.
        step(1'b1, 8'h55, 1'b0, 1'b0);
        idle(TO + 2);
        pair(8'h66, 8'h77);
        step(1'b1, 8'h88, 1'b0, 1'b0);
        idle(TO - 2);
        step(1'b1, 8'h89, 1'b0, 1'b0);
        pops(3);

        // Asynchronous reset mid-word with words queued.
        pair(8'hC3, 8'hC4);
        pair(8'hC5, 8'hC6);
        step(1'b1, 8'h99, 1'b0, 1'b0);
        async_reset();
        check_state("post_rst");
        pair(8'h01, 8'h02);
        pops(1);

        // Pop while empty is ignored.
        pops(2);
        pair(8'hFE, 8'hFF);
        pops(1);

        // Randomised traffic, including occasional long idle gaps.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 49) == 0) idle(TO + 1);
            step(1'($urandom_range(0, 1)), 8'($urandom),
                 1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 19) == 0));
        end
        idle(TO + 1);
        pops(DEPTH + 1);
        chk("drained", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
